fsm_req_gen: RTL
================

FSM_REQ_GEN -- requirements
Module: fsm_req_gen

Interface
REQ-001 Parameter TIMEOUT, default 15, means cycles in REQ without a grant before the job is abandoned (range 1..255).
REQ-002 Parameter LEN_W, default 4, means width of job_len.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 job_valid  input  1  job offer.
REQ-006 job_chan  input  2  target channel 0..3 for the offered job.
REQ-007 job_len  input  LEN_W  beats minus one (0 means 1 beat, 15 means 16 beats).
REQ-008 job_ready  output  1  combinational; channel job_chan can accept a job.
REQ-009 gnt_0, gnt_1, gnt_2, gnt_3  input  1 each  active-high grants from the 4-agent arbiter.
REQ-010 req_0, req_1, req_2, req_3  output  1 each  active-high registered requests to the arbiter.
REQ-011 done  output  4  registered one-cycle pulse per channel on job completion.
REQ-012 timeout  output  4  registered one-cycle pulse per channel on job abandonment.
REQ-013 grant_err  output  1  registered one-cycle pulse when more than one gnt is high.

Function
REQ-014 Each channel x SHALL run an independent FSM with states IDLE, REQ, BUSY, GAP, a LEN_W-bit remaining-beat counter rem_x and an 8-bit wait counter wait_x.
REQ-015 job_ready SHALL be high iff the channel selected by job_chan is in IDLE; a job is accepted at a rising edge where job_valid and job_ready are both high.
REQ-016 IDLE: on acceptance, rem_x loads job_len, wait_x clears, next state REQ; otherwise stays in IDLE.
REQ-017 req_x SHALL be high exactly in REQ and BUSY; high from the first cycle after acceptance (1-cycle latency).
REQ-018 REQ, gnt_x=1: if rem_x==0, pulse done[x] and go to GAP; else decrement rem_x and go to BUSY.
REQ-019 REQ, gnt_x=0: increment wait_x; when wait_x reaches TIMEOUT-1 at that edge, pulse timeout[x] and go to GAP (exactly TIMEOUT grantless cycles in REQ).
REQ-020 BUSY, gnt_x=1: if rem_x==0, pulse done[x] and go to GAP; else decrement rem_x and stay in BUSY.
REQ-021 BUSY, gnt_x=0 (preemption): go to REQ, clear wait_x, retain rem_x; total granted beats per job stays job_len+1.
REQ-022 GAP: req_x low for exactly one cycle, next state IDLE; gnt_x is ignored in GAP and IDLE.
REQ-023 A job SHALL be accepted in the same cycle that its channel's done/timeout pulse is high only if that channel is already back in IDLE (never in GAP).
REQ-024 grant_err SHALL pulse for the cycle after any rising edge at which two or more of gnt_0..gnt_3 are high; channel FSMs still act on their own gnt_x.
REQ-025 rem_x SHALL never wrap: no decrement occurs at 0; wait_x SHALL saturate and never wrap.
REQ-026 Channels SHALL be fully independent; simultaneous completion on several channels SHALL raise several done bits in the same cycle.

Reset
REQ-027 While reset is low, all channels SHALL be IDLE, rem/wait counters zero, and req_0..req_3, done, timeout and grant_err all 0, immediately and regardless of clock.
REQ-028 Reset deasserted mid-job SHALL discard the job with no done or timeout pulse; job_ready SHALL be high for every channel on the first cycle after release.

Verification
REQ-029 Accept job chan 0, len 0; gnt_0 high one cycle after req_0 -> req_0 high 1 cycle after acceptance; done=4'b0001 for 1 cycle; req_0 low for 1 GAP cycle; job_ready high again.
REQ-030 Accept job chan 2, len 3; gnt_2 held high -> exactly 4 granted beats; done[2] pulses once; req_2 drops the cycle after the 4th beat.
REQ-031 Chan 1, len 5; gnt_1 high 2 cycles, low 3, high again -> req_1 stays high throughout; done[1] after 4 further granted beats (6 total).
REQ-032 Chan 3, gnt_3 never asserted, TIMEOUT=15 -> timeout=4'b1000 after exactly 15 REQ cycles; req_3 low; no done pulse.
REQ-033 gnt_0 and gnt_1 high together -> grant_err pulses 1 cycle; offer to a busy channel -> job_ready low and no acceptance.
REQ-034 reset driven low mid-BUSY on chan 2 -> req_2 low asynchronously; no done; new job accepted after reset release.

Source files
------------

// File: rtl/fsm_req_gen_if.sv
// Job-offer and arbiter handshake bundle for the four-channel request generator.
// The master side offers jobs and grants; the slave side (fsm_req_gen) raises requests.
interface fsm_req_gen_if #(
  parameter int LEN_W = 4
);
  logic             job_valid;
  logic [1:0]       job_chan;
  logic [LEN_W-1:0] job_len;
  logic             job_ready;
  logic             gnt_0;
  logic             gnt_1;
  logic             gnt_2;
  logic             gnt_3;
  logic             req_0;
  logic             req_1;
  logic             req_2;
  logic             req_3;
  logic [3:0]       done;
  logic [3:0]       timeout;
  logic             grant_err;

  modport master (
    output job_valid, job_chan, job_len, gnt_0, gnt_1, gnt_2, gnt_3,
    input  job_ready, req_0, req_1, req_2, req_3, done, timeout, grant_err
  );

  modport slave (
    input  job_valid, job_chan, job_len, gnt_0, gnt_1, gnt_2, gnt_3,
    output job_ready, req_0, req_1, req_2, req_3, done, timeout, grant_err
  );
endinterface

// File: rtl/fsm_req_gen.sv
// Four independent IDLE/REQ/BUSY/GAP request generators feeding a 4-agent arbiter.
// Each channel counts remaining beats and grantless REQ cycles; done/timeout/grant_err are one-cycle pulses.
module fsm_req_gen #(
  parameter int TIMEOUT = 15,
  parameter int LEN_W   = 4
) (
  input logic          clock,
  input logic          reset,
  fsm_req_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam logic [7:0]       WAIT_LAST_C = 8'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] LEN_ONE_C   = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO_C  = {LEN_W{1'b0}};

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    if (val == 8'hFF) begin
      sat_inc8 = val;
    end else begin
      sat_inc8 = val + 8'd1;
    end
  endfunction

  function automatic logic multi_grant(input logic [3:0] g);
    multi_grant = (g[0] & g[1]) | (g[0] & g[2]) | (g[0] & g[3]) |
                  (g[1] & g[2]) | (g[1] & g[3]) | (g[2] & g[3]);
  endfunction

  state_e           state_r [4];
  logic [LEN_W-1:0] rem_r   [4];
  logic [7:0]       wait_r  [4];
  logic [3:0]       req_r;
  logic [3:0]       done_r;
  logic [3:0]       timeout_r;
  logic             grant_err_r;

  logic [3:0]       gnt_s;
  logic             ready_s;
  logic             accept_s;

  assign gnt_s    = {bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_0};
  assign ready_s  = (state_r[bus.job_chan] == ST_IDLE);
  assign accept_s = bus.job_valid & ready_s;

  assign bus.job_ready = ready_s;
  assign bus.req_0     = req_r[0];
  assign bus.req_1     = req_r[1];
  assign bus.req_2     = req_r[2];
  assign bus.req_3     = req_r[3];
  assign bus.done      = done_r;
  assign bus.timeout   = timeout_r;
  assign bus.grant_err = grant_err_r;

  // Per-channel FSMs; req mirrors the next state so it is high exactly in REQ and BUSY.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        state_r[i] <= ST_IDLE;
        rem_r[i]   <= LEN_ZERO_C;
        wait_r[i]  <= 8'd0;
      end
      req_r       <= 4'b0000;
      done_r      <= 4'b0000;
      timeout_r   <= 4'b0000;
      grant_err_r <= 1'b0;
    end else begin
      grant_err_r <= multi_grant(gnt_s);
      for (int i = 0; i < 4; i++) begin
        done_r[i]    <= 1'b0;
        timeout_r[i] <= 1'b0;
        case (state_r[i])
          ST_IDLE: begin
            if (accept_s && (bus.job_chan == 2'(i))) begin
              rem_r[i]   <= bus.job_len;
              wait_r[i]  <= 8'd0;
              state_r[i] <= ST_REQ;
              req_r[i]   <= 1'b1;
            end else begin
              req_r[i]   <= 1'b0;
            end
          end
          ST_REQ: begin
            if (gnt_s[i]) begin
              if (rem_r[i] == LEN_ZERO_C) begin
                done_r[i]  <= 1'b1;
                state_r[i] <= ST_GAP;
                req_r[i]   <= 1'b0;
              end else begin
                rem_r[i]   <= rem_r[i] - LEN_ONE_C;
                state_r[i] <= ST_BUSY;
                req_r[i]   <= 1'b1;
              end
            end else begin
              wait_r[i] <= sat_inc8(wait_r[i]);
              if (wait_r[i] >= WAIT_LAST_C) begin
                timeout_r[i] <= 1'b1;
                state_r[i]   <= ST_GAP;
                req_r[i]     <= 1'b0;
              end else begin
                req_r[i]     <= 1'b1;
              end
            end
          end
          ST_BUSY: begin
            if (gnt_s[i]) begin
              if (rem_r[i] == LEN_ZERO_C) begin
                done_r[i]  <= 1'b1;
                state_r[i] <= ST_GAP;
                req_r[i]   <= 1'b0;
              end else begin
                rem_r[i]   <= rem_r[i] - LEN_ONE_C;
                req_r[i]   <= 1'b1;
              end
            end else begin
              // Preempted: re-request with a fresh wait budget, beat count kept.
              wait_r[i]  <= 8'd0;
              state_r[i] <= ST_REQ;
              req_r[i]   <= 1'b1;
            end
          end
          ST_GAP: begin
            state_r[i] <= ST_IDLE;
            req_r[i]   <= 1'b0;
          end
          default: begin
            state_r[i] <= ST_IDLE;
            req_r[i]   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
